ram_rect_filler: RTL and testbench

RAM_RECT_FILLER -- requirements
Module: ram_rect_filler

---
 rtl/ram_rect_filler_if.sv | 33 +++
 rtl/ram_rect_filler.sv | 126 ++++++++++++
 tb/tb_ram_rect_filler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ram_rect_filler_if.sv
// Command and RAM-write bundle between a rectangle-fill client and ram_rect_filler.
// The slave modport is the filler's view; the master modport is the client/RAM side.
interface ram_rect_filler_if #(
    parameter int DATA_WIDTH = 7,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 4
);
    localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH;

    logic                  clear_i;
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [X_WIDTH-1:0]    cmd_x_i;
    logic [Y_WIDTH-1:0]    cmd_y_i;
    logic [X_WIDTH-1:0]    cmd_w_i;
    logic [Y_WIDTH-1:0]    cmd_h_i;
    logic [DATA_WIDTH-1:0] cmd_data_i;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] write_addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  clear_i, cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_data_i,
        output cmd_ready_o, we_o, write_addr_o, data_o, busy_o, done_o
    );

    modport master (
        output clear_i, cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_data_i,
        input  cmd_ready_o, we_o, write_addr_o, data_o, busy_o, done_o
    );
endinterface

// File: rtl/ram_rect_filler.sv
// Clears a 2D RAM, then fills row-major rectangles: one registered write per cycle, first write
// the edge after acceptance. Commands are refused while busy or while clear_i is high.
module ram_rect_filler #(
    parameter int                   DATA_WIDTH  = 7,
    parameter int                   X_WIDTH     = 5,
    parameter int                   Y_WIDTH     = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    ram_rect_filler_if.slave   bus
);
    localparam int ADDR_WIDTH = X_WIDTH + Y_WIDTH;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [X_WIDTH-1:0]    x0;
    logic [X_WIDTH-1:0]    cur_x;
    logic [X_WIDTH-1:0]    w_r;
    logic [X_WIDTH-1:0]    col_cnt;
    logic [Y_WIDTH-1:0]    cur_y;
    logic [Y_WIDTH-1:0]    h_r;
    logic [Y_WIDTH-1:0]    row_cnt;
    logic [DATA_WIDTH-1:0] fill_dat;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  done_q;

    assign bus.cmd_ready_o  = (state == ST_IDLE) && !bus.clear_i;
    assign bus.busy_o       = (state != ST_IDLE);
    assign bus.we_o         = we_q;
    assign bus.write_addr_o = addr_q;
    assign bus.data_o       = dat_q;
    assign bus.done_o       = done_q;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            x0       <= '0;
            cur_x    <= '0;
            w_r      <= '0;
            col_cnt  <= '0;
            cur_y    <= '0;
            h_r      <= '0;
            row_cnt  <= '0;
            fill_dat <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            dat_q    <= '0;
            done_q   <= 1'b0;
        end else if (bus.clear_i) begin
            // Clear wins everywhere: this edge already writes address 0, sweep resumes at 1.
            state   <= ST_CLEAR;
            we_q    <= 1'b1;
            addr_q  <= '0;
            dat_q   <= CLEAR_VALUE;
            clr_cnt <= ADDR_WIDTH'(1);
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    we_q    <= 1'b1;
                    addr_q  <= clr_cnt;
                    dat_q   <= CLEAR_VALUE;
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (&clr_cnt) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.cmd_valid_i) begin
                        state    <= ST_FILL;
                        x0       <= bus.cmd_x_i;
                        cur_x    <= bus.cmd_x_i;
                        cur_y    <= bus.cmd_y_i;
                        w_r      <= bus.cmd_w_i;
                        h_r      <= bus.cmd_h_i;
                        fill_dat <= bus.cmd_data_i;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                    end
                end
                ST_FILL: begin
                    we_q   <= 1'b1;
                    addr_q <= {cur_y, cur_x};
                    dat_q  <= fill_dat;
                    // Coordinates wrap independently; column overflow never carries into the row.
                    if (col_cnt == w_r) begin
                        col_cnt <= '0;
                        cur_x   <= x0;
                        if (row_cnt == h_r) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + Y_WIDTH'(1);
                            cur_y   <= cur_y + Y_WIDTH'(1);
                            done_q  <= 1'b0;
                        end
                    end else begin
                        col_cnt <= col_cnt + X_WIDTH'(1);
                        cur_x   <= cur_x + X_WIDTH'(1);
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_rect_filler.sv
// Directed bench for ram_rect_filler: reset, clear sweep, fills with wrap, clear abort and priority.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_ram_rect_filler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    ram_rect_filler_if #(.DATA_WIDTH(7), .X_WIDTH(5), .Y_WIDTH(4)) bus ();

    ram_rect_filler #(
        .DATA_WIDTH (7),
        .X_WIDTH    (5),
        .Y_WIDTH    (4),
        .CLEAR_VALUE(7'h00)
    ) dut (
        .clock_i (clk),
        .reset_ni(rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.clear_i    = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_x_i    = '0;
        bus.cmd_y_i    = '0;
        bus.cmd_w_i    = '0;
        bus.cmd_h_i    = '0;
        bus.cmd_data_i = '0;
        tick();
        tick();
        n_cmp++; if (bus.we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", bus.we_o); end
        n_cmp++; if (bus.write_addr_o !== 9'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.write_addr_o); end
        n_cmp++; if (bus.data_o !== 7'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.data_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", bus.busy_o); end
        n_cmp++; if (bus.cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.cmd_ready_o); end
    endtask

    // Checks sweep writes first..511 on consecutive edges, then the IDLE cycle after.
    task automatic check_sweep(input int first, input string name);
        for (int i = first; i < 512; i++) begin
            tick();
            n_cmp++; if (bus.we_o !== 1'b1) begin n_err++; $display("FAIL %s_we[%0d] got %b want 1", name, i, bus.we_o); end
            n_cmp++; if (bus.write_addr_o !== 9'(i)) begin n_err++; $display("FAIL %s_addr[%0d] got %0d want %0d", name, i, bus.write_addr_o, i); end
            n_cmp++; if (bus.data_o !== 7'h00) begin n_err++; $display("FAIL %s_data[%0d] got %h want 00", name, i, bus.data_o); end
            n_cmp++; if (bus.done_o !== (i == 511)) begin n_err++; $display("FAIL %s_done[%0d] got %b want %b", name, i, bus.done_o, (i == 511)); end
        end
        n_cmp++; if (bus.cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL %s_ready_after got %b want 1", name, bus.cmd_ready_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL %s_busy_after got %b want 0", name, bus.busy_o); end
        tick();
        n_cmp++; if (bus.we_o !== 1'b0) begin n_err++; $display("FAIL %s_we_idle got %b want 0", name, bus.we_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL %s_done_idle got %b want 0", name, bus.done_o); end
        n_cmp++; if (bus.write_addr_o !== 9'd511) begin n_err++; $display("FAIL %s_addr_hold got %0d want 511", name, bus.write_addr_o); end
    endtask

    task automatic test_clear_sweep();
        rst_n = 1'b1;
        check_sweep(0, "sweep");
    endtask

    // Issues one command and expects writes at exp_q; junk=1 keeps a bogus command valid while busy.
    task automatic run_fill(input logic [4:0] x, input logic [3:0] y, input logic [4:0] w,
                            input logic [3:0] h, input logic [6:0] d, input bit junk, input string name);
        int last;
        last = exp_q.size() - 1;
        bus.cmd_x_i = x; bus.cmd_y_i = y; bus.cmd_w_i = w; bus.cmd_h_i = h; bus.cmd_data_i = d;
        bus.cmd_valid_i = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready_o !== 1'b1) begin n_err++; $display("FAIL %s_ready got %b want 1", name, bus.cmd_ready_o); end
        tick();
        bus.cmd_valid_i = junk;
        bus.cmd_x_i = 5'd0; bus.cmd_y_i = 4'd0; bus.cmd_w_i = 5'd1; bus.cmd_h_i = 4'd1; bus.cmd_data_i = 7'h01;
        #1;
        n_cmp++; if (bus.we_o !== 1'b0) begin n_err++; $display("FAIL %s_we_accept got %b want 0", name, bus.we_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL %s_busy got %b want 1", name, bus.busy_o); end
        n_cmp++; if (bus.cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL %s_ready_busy got %b want 0", name, bus.cmd_ready_o); end
        for (int k = 0; k <= last; k++) begin
            tick();
            if (k == last) bus.cmd_valid_i = 1'b0;
            n_cmp++; if (bus.we_o !== 1'b1) begin n_err++; $display("FAIL %s_we[%0d] got %b want 1", name, k, bus.we_o); end
            n_cmp++; if (bus.write_addr_o !== 9'(exp_q[k])) begin n_err++; $display("FAIL %s_addr[%0d] got %0d want %0d", name, k, bus.write_addr_o, exp_q[k]); end
            n_cmp++; if (bus.data_o !== d) begin n_err++; $display("FAIL %s_data[%0d] got %h want %h", name, k, bus.data_o, d); end
            n_cmp++; if (bus.done_o !== (k == last)) begin n_err++; $display("FAIL %s_done[%0d] got %b want %b", name, k, bus.done_o, (k == last)); end
        end
        tick();
        n_cmp++; if (bus.we_o !== 1'b0) begin n_err++; $display("FAIL %s_we_end got %b want 0", name, bus.we_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL %s_done_end got %b want 0", name, bus.done_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL %s_busy_end got %b want 0", name, bus.busy_o); end
        n_cmp++; if (bus.write_addr_o !== 9'(exp_q[last])) begin n_err++; $display("FAIL %s_addr_hold got %0d want %0d", name, bus.write_addr_o, exp_q[last]); end
    endtask

    task automatic test_single_cell();
        exp_q = '{163};
        run_fill(5'd3, 4'd5, 5'd0, 4'd0, 7'h2A, 1'b0, "single");
    endtask

    task automatic test_rect();
        exp_q = '{68, 69, 70, 100, 101, 102};
        run_fill(5'd4, 4'd2, 5'd2, 4'd1, 7'h55, 1'b1, "rect");
    endtask

    task automatic test_wrap();
        exp_q = '{510, 511, 480, 481, 30, 31, 0, 1};
        run_fill(5'd30, 4'd15, 5'd3, 4'd1, 7'h7F, 1'b0, "wrap");
    endtask

    task automatic test_clear_abort();
        bus.cmd_x_i = 5'd1; bus.cmd_y_i = 4'd1; bus.cmd_w_i = 5'd2; bus.cmd_h_i = 4'd2; bus.cmd_data_i = 7'h15;
        bus.cmd_valid_i = 1'b1;
        tick();
        bus.cmd_valid_i = 1'b0;
        exp_q = '{33, 34, 35};
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (bus.write_addr_o !== 9'(exp_q[k])) begin n_err++; $display("FAIL abort_fill_addr[%0d] got %0d want %0d", k, bus.write_addr_o, exp_q[k]); end
        end
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        n_cmp++; if (bus.we_o !== 1'b1) begin n_err++; $display("FAIL abort_we got %b want 1", bus.we_o); end
        n_cmp++; if (bus.write_addr_o !== 9'd0) begin n_err++; $display("FAIL abort_addr got %0d want 0", bus.write_addr_o); end
        n_cmp++; if (bus.data_o !== 7'h00) begin n_err++; $display("FAIL abort_data got %h want 00", bus.data_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", bus.done_o); end
        check_sweep(1, "abort");
    endtask

    task automatic test_clear_priority();
        bus.cmd_x_i = 5'd3; bus.cmd_y_i = 4'd5; bus.cmd_w_i = 5'd0; bus.cmd_h_i = 4'd0; bus.cmd_data_i = 7'h2A;
        bus.cmd_valid_i = 1'b1;
        bus.clear_i = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready_o !== 1'b0) begin n_err++; $display("FAIL prio_ready got %b want 0", bus.cmd_ready_o); end
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.clear_i = 1'b0;
        n_cmp++; if (bus.we_o !== 1'b1) begin n_err++; $display("FAIL prio_we got %b want 1", bus.we_o); end
        n_cmp++; if (bus.write_addr_o !== 9'd0) begin n_err++; $display("FAIL prio_addr got %0d want 0", bus.write_addr_o); end
        n_cmp++; if (bus.data_o !== 7'h00) begin n_err++; $display("FAIL prio_data got %h want 00", bus.data_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL prio_busy got %b want 1", bus.busy_o); end
        check_sweep(1, "prio");
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_single_cell();
        test_rect();
        test_wrap();
        test_clear_abort();
        test_clear_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
